simplex_pivot_ctrl: RTL and testbench

SIMPLEX_PIVOT_CTRL -- requirements
Module: simplex_pivot_ctrl

---
 rtl/simplex_pkg.sv | 25 ++
 rtl/simplex_pivot_idx_gen.sv | 59 +++++
 rtl/simplex_pivot_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_simplex_pivot_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplex_pkg.sv
// Shared types for the simplex pivot controller: datapath op kinds and
// controller states, imported by the controller and its index generator.
package simplex_pkg;

    typedef enum logic {
        OP_NORM = 1'b0,
        OP_ELIM = 1'b1
    } op_kind_e;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        RD_PIV,
        NORM_RD,
        NORM_OP,
        NORM_WR,
        ROW_RD_F,
        ELIM_RD_A,
        ELIM_RD_C,
        ELIM_OP,
        ELIM_WR,
        FINISH
    } state_e;

endpackage

// File: rtl/simplex_pivot_idx_gen.sv
// Row/column walker for the pivot sequence: column wraps at num_cols-1,
// row skips the pivot row.
// Ports: clk/rst, init (row=first non-pivot, col=0), col_inc, row_inc,
//   sizes and pivot row in; row/col indices and col_last/row_last out.
module simplex_pivot_idx_gen
    import simplex_pkg::*;
#(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             col_inc,
    input  logic             row_inc,
    input  logic [ROW_W-1:0] num_rows,
    input  logic [ROW_W-1:0] piv_row,
    input  logic [COL_W-1:0] num_cols,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             col_last,
    output logic             row_last
);

    localparam logic [ROW_W:0] R_ONE = (ROW_W+1)'(1);
    localparam logic [COL_W:0] C_ONE = (COL_W+1)'(1);

    logic [ROW_W:0] row_p1;
    logic [ROW_W:0] row_nxt;
    logic [COL_W:0] col_p1;

    // One extra bit so "past the last row" is representable.
    always_comb begin
        row_p1  = {1'b0, row} + R_ONE;
        row_nxt = row_p1;
        if (row_p1 == {1'b0, piv_row})
            row_nxt = row_p1 + R_ONE;
        col_p1  = {1'b0, col} + C_ONE;
    end

    assign col_last = (col_p1 == {1'b0, num_cols});
    assign row_last = (row_nxt >= {1'b0, num_rows});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (init) begin
            row <= (piv_row == '0) ? ROW_W'(1) : '0;
            col <= '0;
        end else begin
            if (col_inc)
                col <= col_last ? '0 : col_p1[COL_W-1:0];
            if (row_inc)
                row <= row_nxt[ROW_W-1:0];
        end
    end

endmodule

// File: rtl/simplex_pivot_ctrl.sv
// Simplex pivot sequencer: normalizes the pivot row, then eliminates the
// pivot column from every other row through an external datapath.
// Ports: ACLK/ARESET; start + tableau size + pivot position in;
//   busy/done/err status; tableau read (1-cycle latency) and write ports;
//   op_valid/op_ready command and res_valid/res_data result handshakes.
// Option: SIMPLEX_PIVOT_CTRL_SKIP_ZERO_EN skips rows whose factor is zero.
module simplex_pivot_ctrl
    import simplex_pkg::*;
#(
    parameter int ROW_W  = 4,
    parameter int COL_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   start,
    input  logic [ROW_W-1:0]       num_rows,
    input  logic [COL_W-1:0]       num_cols,
    input  logic [ROW_W-1:0]       pivot_row,
    input  logic [COL_W-1:0]       pivot_col,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   mem_rd_en,
    output logic [ROW_W+COL_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0]      mem_rd_data,
    output logic                   mem_wr_en,
    output logic [ROW_W+COL_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0]      mem_wr_data,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic                   op_kind,
    output logic [DATA_W-1:0]      op_a,
    output logic [DATA_W-1:0]      op_b,
    output logic [DATA_W-1:0]      op_c,
    input  logic                   res_valid,
    input  logic [DATA_W-1:0]      res_data
);

    state_e state, state_nxt;

    logic [ROW_W-1:0]  nr_q, pr_q;
    logic [COL_W-1:0]  nc_q, pc_q;
    logic [DATA_W-1:0] piv_q, a_q, c_q, fac_q, res_q;
    logic              err_q;
    // rd_wait: second cycle of a read state, mem_rd_data valid.
    logic              rd_wait;
    // op_sent: command accepted, waiting for its result.
    logic              op_sent;

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             col_last, row_last;

    logic accept, bad_cfg, rd_state, op_state;
    logic rd_done, res_hit, rd_zero, skip_row;
    logic idx_init, col_inc, row_inc;

    assign accept   = (state == IDLE) && start;
    assign bad_cfg  = (pr_q >= nr_q) || (pc_q >= nc_q) ||
                      (nr_q == '0) || (nc_q == '0);
    assign rd_state = state inside {RD_PIV, NORM_RD, ROW_RD_F,
                                    ELIM_RD_A, ELIM_RD_C};
    assign op_state = (state == NORM_OP) || (state == ELIM_OP);
    assign rd_done  = rd_state && rd_wait;
    assign res_hit  = op_state && op_sent && res_valid;
    assign rd_zero  = (mem_rd_data == '0);

`ifdef SIMPLEX_PIVOT_CTRL_SKIP_ZERO_EN
    assign skip_row = (state == ROW_RD_F) && rd_wait && rd_zero;
`else
    assign skip_row = 1'b0;
`endif

    assign idx_init = (state == CHECK);
    assign col_inc  = (state == NORM_WR) || (state == ELIM_WR);
    assign row_inc  = ((state == ELIM_WR) && col_last) || skip_row;

    simplex_pivot_idx_gen #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_idx (
        .clk      (ACLK),
        .rst      (ARESET),
        .init     (idx_init),
        .col_inc  (col_inc),
        .row_inc  (row_inc),
        .num_rows (nr_q),
        .piv_row  (pr_q),
        .num_cols (nc_q),
        .row      (row),
        .col      (col),
        .col_last (col_last),
        .row_last (row_last)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (start) state_nxt = CHECK;
            CHECK:     state_nxt = bad_cfg ? FINISH : RD_PIV;
            RD_PIV:
                if (rd_wait)
                    state_nxt = rd_zero ? FINISH : NORM_RD;
            NORM_RD:   if (rd_wait) state_nxt = NORM_OP;
            NORM_OP:   if (res_hit) state_nxt = NORM_WR;
            NORM_WR:
                if (!col_last)
                    state_nxt = NORM_RD;
                else if (nr_q == ROW_W'(1))
                    state_nxt = FINISH;
                else
                    state_nxt = ROW_RD_F;
            ROW_RD_F:
                if (skip_row)
                    state_nxt = row_last ? FINISH : ROW_RD_F;
                else if (rd_wait)
                    state_nxt = ELIM_RD_A;
            ELIM_RD_A: if (rd_wait) state_nxt = ELIM_RD_C;
            ELIM_RD_C: if (rd_wait) state_nxt = ELIM_OP;
            ELIM_OP:   if (res_hit) state_nxt = ELIM_WR;
            ELIM_WR:
                if (!col_last)
                    state_nxt = ELIM_RD_A;
                else
                    state_nxt = row_last ? FINISH : ROW_RD_F;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = (state == FINISH);
        err         = err_q;
        mem_rd_en   = rd_state && !rd_wait;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = res_q;
        op_valid    = op_state && !op_sent;
        op_kind     = OP_NORM;
        op_a        = a_q;
        op_b        = piv_q;
        op_c        = '0;
        unique case (state)
            RD_PIV:    mem_rd_addr = {pr_q, pc_q};
            NORM_RD:   mem_rd_addr = {pr_q, col};
            ROW_RD_F:  mem_rd_addr = {row, pc_q};
            ELIM_RD_A: mem_rd_addr = {row, col};
            ELIM_RD_C: mem_rd_addr = {pr_q, col};
            NORM_WR: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = {pr_q, col};
            end
            ELIM_WR: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = {row, col};
            end
            ELIM_OP: begin
                op_kind = OP_ELIM;
                op_b    = fac_q;
                op_c    = c_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            nr_q    <= '0;
            nc_q    <= '0;
            pr_q    <= '0;
            pc_q    <= '0;
            piv_q   <= '0;
            a_q     <= '0;
            c_q     <= '0;
            fac_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            rd_wait <= 1'b0;
            op_sent <= 1'b0;
        end else begin
            rd_wait <= rd_state && !rd_wait;
            if (op_state) begin
                if (!op_sent && op_ready)
                    op_sent <= 1'b1;
                else if (op_sent && res_valid)
                    op_sent <= 1'b0;
            end
            if (accept) begin
                nr_q  <= num_rows;
                nc_q  <= num_cols;
                pr_q  <= pivot_row;
                pc_q  <= pivot_col;
                err_q <= 1'b0;
            end
            unique case (state)
                CHECK:
                    if (bad_cfg) err_q <= 1'b1;
                RD_PIV:
                    if (rd_wait) begin
                        piv_q <= mem_rd_data;
                        if (rd_zero) err_q <= 1'b1;
                    end
                NORM_RD, ELIM_RD_A:
                    if (rd_wait) a_q <= mem_rd_data;
                ELIM_RD_C:
                    if (rd_wait) c_q <= mem_rd_data;
                ROW_RD_F:
                    if (rd_wait) fac_q <= mem_rd_data;
                NORM_OP, ELIM_OP:
                    if (res_hit) res_q <= res_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simplex_pivot_ctrl.sv
// Directed bench for simplex_pivot_ctrl with a tableau memory model and a
// variable-latency pivot datapath model.
module tb_simplex_pivot_ctrl;

    localparam int ROW_W  = 4;
    localparam int COL_W  = 4;
    localparam int DATA_W = 32;
`ifdef SIMPLEX_PIVOT_CTRL_SKIP_ZERO_EN
    localparam int ZE_ELIM = 3;
`else
    localparam int ZE_ELIM = 6;
`endif

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              start;
    logic [ROW_W-1:0]  num_rows, pivot_row;
    logic [COL_W-1:0]  num_cols, pivot_col;
    logic              busy, done, err;
    logic              mem_rd_en, mem_wr_en;
    logic [7:0]        mem_rd_addr, mem_wr_addr;
    logic [31:0]       mem_rd_data = '0;
    logic [31:0]       mem_wr_data;
    logic              op_valid, op_kind;
    logic              op_ready;
    logic [31:0]       op_a, op_b, op_c;
    logic              res_valid = 1'b0;
    logic [31:0]       res_data = '0;

    always #5 ACLK = ~ACLK;

    simplex_pivot_ctrl #(
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .DATA_W(DATA_W)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .start      (start),
        .num_rows   (num_rows),
        .num_cols   (num_cols),
        .pivot_row  (pivot_row),
        .pivot_col  (pivot_col),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_kind    (op_kind),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_c       (op_c),
        .res_valid  (res_valid),
        .res_data   (res_data)
    );

    logic [31:0] mem [256];
    logic [31:0] tab [256];
    logic        do_load = 1'b0;

    always @(posedge ACLK) begin
        if (do_load) begin
            for (int k = 0; k < 256; k++) mem[k] <= tab[k];
        end else if (mem_wr_en) begin
            mem[mem_wr_addr] <= mem_wr_data;
        end
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    logic        pend = 1'b0;
    logic [31:0] pend_val = '0;
    int          lat_cnt = 0;
    int          n_acc = 0;

    always @(posedge ACLK) begin
        res_valid <= 1'b0;
        if (ARESET) begin
            pend <= 1'b0;
        end else if (op_valid && op_ready) begin
            pend    <= 1'b1;
            lat_cnt <= (n_acc % 2 == 0) ? 0 : 2;
            n_acc   <= n_acc + 1;
            if (op_kind)
                pend_val <= op_a - op_b * op_c;
            else
                pend_val <= $signed(op_a) / $signed(op_b);
        end else if (pend) begin
            if (lat_cnt == 0) begin
                res_valid <= 1'b1;
                res_data  <= pend_val;
                pend      <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    int          norm_cnt = 0, elim_cnt = 0, wr_cnt = 0;
    int          done_cnt = 0, viol_cnt = 0;
    logic        hold_q = 1'b0;
    logic [96:0] op_q = '0;

    always @(posedge ACLK) begin
        if (!ARESET) begin
            if (op_valid && op_ready) begin
                if (op_kind) elim_cnt <= elim_cnt + 1;
                else         norm_cnt <= norm_cnt + 1;
            end
            if (mem_wr_en) wr_cnt <= wr_cnt + 1;
            if (done)      done_cnt <= done_cnt + 1;
            if ((mem_wr_en && mem_rd_en) ||
                (hold_q && (!op_valid ||
                 {op_kind, op_a, op_b, op_c} != op_q)))
                viol_cnt <= viol_cnt + 1;
        end
        hold_q <= op_valid && !op_ready && !ARESET;
        op_q   <= {op_kind, op_a, op_b, op_c};
    end

    typedef struct {
        int nr, nc, pr, pc;
        int e_err, e_wr, e_norm, e_elim, max_cyc;
        int e_mem [9];
    } vec_t;

    int checks = 0, failures = 0;
    int base [9] = '{2, 4, 6, 3, 1, 5, 4, 2, 0};
    int exp6 [9] = '{1, 2, 3, 0, -5, -4, 0, -6, -12};
    int zt   [9] = '{2, 4, 6, 0, 1, 5, 4, 2, 0};
    int ze   [9] = '{1, 2, 3, 0, 1, 5, 0, -6, -12};
    vec_t vecs [9];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm,
                     $signed(act), $signed(exp));
        end
    endtask

    task automatic check_mem(input string nm, input int exp [9]);
        int bad = 0;
        int fi = 0;
        checks++;
        for (int i = 0; i < 9; i++) begin
            if (mem[(i / 3) * 16 + (i % 3)] !== 32'(exp[i])) begin
                if (bad == 0) fi = i;
                bad++;
            end
        end
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_mem: %0d cells differ, [%0d][%0d] got %0d expected %0d",
                     nm, bad, fi / 3, fi % 3,
                     $signed(mem[(fi / 3) * 16 + (fi % 3)]), exp[fi]);
        end
    endtask

    task automatic load_tab(input int t [9]);
        for (int k = 0; k < 256; k++) tab[k] = '0;
        for (int i = 0; i < 9; i++) tab[(i / 3) * 16 + (i % 3)] = 32'(t[i]);
        @(negedge ACLK);
        do_load = 1'b1;
        @(negedge ACLK);
        do_load = 1'b0;
    endtask

    task automatic pulse_start(input int nr, nc, pr, pc);
        @(negedge ACLK);
        num_rows  = ROW_W'(nr);
        num_cols  = COL_W'(nc);
        pivot_row = ROW_W'(pr);
        pivot_col = COL_W'(pc);
        start     = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc,
                             output logic ok, output logic e);
        cyc = 1;
        while (!done && cyc < budget) begin
            @(negedge ACLK);
            cyc++;
        end
        ok = done;
        e  = err;
    endtask

    task automatic finish_run(input string nm, input int e_err, e_wr,
                              e_norm, e_elim, input int e_mem [9],
                              input int w0, n0, l0, d0);
        int   cyc;
        logic ok, e;
        wait_done(2000, cyc, ok, e);
        @(negedge ACLK);
        check({nm, "_done"}, 32'(ok), 1);
        check({nm, "_err"}, 32'(e), 32'(e_err));
        check({nm, "_ndone"}, done_cnt - d0, 1);
        check({nm, "_writes"}, wr_cnt - w0, e_wr);
        check({nm, "_norm"}, norm_cnt - n0, e_norm);
        check({nm, "_elim"}, elim_cnt - l0, e_elim);
        check({nm, "_busy"}, 32'(busy), 0);
        check_mem(nm, e_mem);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int   cyc;
        logic ok, e;
        int   w0, n0, l0, d0;
        load_tab(base);
        w0 = wr_cnt; n0 = norm_cnt; l0 = elim_cnt; d0 = done_cnt;
        pulse_start(v.nr, v.nc, v.pr, v.pc);
        if (v.max_cyc > 0) begin
            wait_done(v.max_cyc + 1, cyc, ok, e);
            checks++;
            if (!ok || cyc > v.max_cyc) begin
                failures++;
                $display("FAIL %s_lat: cycles=%0d limit=%0d", nm, cyc,
                         v.max_cyc);
            end
        end
        finish_run(nm, v.e_err, v.e_wr, v.e_norm, v.e_elim, v.e_mem,
                   w0, n0, l0, d0);
    endtask

    initial begin
        int   k;
        int   w0, n0, l0, d0;
        vecs[0] = '{3, 3, 3, 0, 1, 0, 0, 0, 3, base};
        vecs[1] = '{3, 3, 0, 3, 1, 0, 0, 0, 3, base};
        vecs[2] = '{0, 3, 0, 0, 1, 0, 0, 0, 3, base};
        vecs[3] = '{3, 0, 0, 0, 1, 0, 0, 0, 3, base};
        vecs[4] = '{3, 3, 2, 2, 1, 0, 0, 0, 0, base};
        vecs[5] = '{1, 3, 0, 0, 0, 3, 3, 0, 0,
                    '{1, 2, 3, 3, 1, 5, 4, 2, 0}};
        vecs[6] = '{3, 3, 0, 0, 0, 9, 3, 6, 0, exp6};
        vecs[7] = '{3, 3, 2, 1, 0, 9, 3, 6, 0,
                    '{-6, 0, 6, 1, 0, 5, 2, 1, 0}};
        vecs[8] = '{3, 2, 1, 1, 0, 6, 2, 4, 0,
                    '{-10, 0, 6, 3, 1, 5, -2, 0, 0}};

        ARESET = 1'b1; start = 1'b0; op_ready = 1'b1;
        num_rows = '0; num_cols = '0; pivot_row = '0; pivot_col = '0;
        repeat (3) @(negedge ACLK);
        check("reset_outs",
              {busy, done, err, mem_rd_en, mem_wr_en, op_valid}, 0);
        ARESET = 1'b0;

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        // Datapath stalls on the first NORM; a second start is ignored.
        load_tab(base);
        w0 = wr_cnt; n0 = norm_cnt; l0 = elim_cnt; d0 = done_cnt;
        op_ready = 1'b0;
        pulse_start(3, 3, 0, 0);
        k = 0;
        while (!op_valid && k < 200) begin
            @(negedge ACLK);
            k++;
        end
        check("stall_seen", 32'(op_valid), 1);
        check("stall_busy", 32'(busy), 1);
        for (int s = 0; s < 5; s++) begin
            check("stall_valid", 32'(op_valid), 1);
            check("stall_kind", 32'(op_kind), 0);
            check("stall_a", op_a, 2);
            check("stall_b", op_b, 2);
            start     = (s == 2);
            pivot_row = ROW_W'(1);
            @(negedge ACLK);
        end
        start = 1'b0;
        op_ready = 1'b1;
        finish_run("stall", 0, 9, 3, 6, exp6, w0, n0, l0, d0);

        // Row 1 has a zero factor in the pivot column.
        load_tab(zt);
        w0 = wr_cnt; n0 = norm_cnt; l0 = elim_cnt; d0 = done_cnt;
        pulse_start(3, 3, 0, 0);
        finish_run("zfac", 0, 3 + ZE_ELIM, 3, ZE_ELIM, ze, w0, n0, l0, d0);

        // Reset while an ELIM command is pending.
        load_tab(base);
        pulse_start(3, 3, 0, 0);
        k = 0;
        while (!(op_valid && op_kind) && k < 500) begin
            @(negedge ACLK);
            k++;
        end
        check("rst_elim_seen", 32'(op_valid && op_kind), 1);
        w0 = wr_cnt; d0 = done_cnt;
        ARESET = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_outs", {op_valid, mem_wr_en, mem_rd_en, done}, 0);
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("rst_no_write", wr_cnt - w0, 0);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_err", 32'(err), 0);
        run_vec(vecs[6], "after_rst");

        check("protocol", viol_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
